// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the instruction/data memory port arbiter:
//   arb_state_e  - arbiter FSM states (IDLE, BUSY_I, BUSY_D, DONE)
//   MEM_W_*      - data access width codes carried on dm_width_i
//   DW, LANES    - data width and number of byte lanes
// ---------------------------------------------------------------------------
package mem_arb_pkg;

    localparam int DW    = 32;
    localparam int LANES = DW / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2,
        DONE   = 2'd3
    } arb_state_e;

    localparam logic [1:0] MEM_W_BYTE = 2'b00;
    localparam logic [1:0] MEM_W_HALF = 2'b01;
    localparam logic [1:0] MEM_W_WORD = 2'b10;
    localparam logic [1:0] MEM_W_ILL  = 2'b11;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter_if
// Bundles the fetch (if_*), data (dm_*) and memory (mem_*) ports of the
// arbiter, plus a debug view of the arbiter FSM state.
//   modport master : the arbiter's view
//   modport slave  : the environment's view (pipeline stages + memory model)
// Handshake: a requester raises *_req_i with stable payload and holds it until
// the one-cycle *_ack_o pulse; the arbiter raises mem_req_o with stable payload
// and holds it until the memory returns a one-cycle mem_ack_i.
// ---------------------------------------------------------------------------
interface mem_port_arbiter_if #(
    parameter int AW = 32
) ();

    // instruction fetch side
    logic                      if_req_i;
    logic [AW-1:0]             if_addr_i;
    logic                      if_ack_o;
    logic [mem_arb_pkg::DW-1:0] if_rdata_o;

    // data access side
    logic                      dm_req_i;
    logic                      dm_we_i;
    logic [AW-1:0]             dm_addr_i;
    logic [1:0]                dm_width_i;
    logic                      dm_sext_i;
    logic [mem_arb_pkg::DW-1:0] dm_wdata_i;
    logic                      dm_ack_o;
    logic [mem_arb_pkg::DW-1:0] dm_rdata_o;
    logic                      dm_err_o;

    // memory side
    logic                         mem_req_o;
    logic                         mem_we_o;
    logic [AW-1:0]                mem_addr_o;
    logic [mem_arb_pkg::LANES-1:0] mem_be_o;
    logic [mem_arb_pkg::DW-1:0]    mem_wdata_o;
    logic                         mem_ack_i;
    logic [mem_arb_pkg::DW-1:0]    mem_rdata_i;

    // debug
    mem_arb_pkg::arb_state_e   arb_state_o;

    modport master (
        input  if_req_i, if_addr_i,
        output if_ack_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_width_i, dm_sext_i, dm_wdata_i,
        output dm_ack_o, dm_rdata_o, dm_err_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i,
        output arb_state_o
    );

    modport slave (
        output if_req_i, if_addr_i,
        input  if_ack_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_width_i, dm_sext_i, dm_wdata_i,
        input  dm_ack_o, dm_rdata_o, dm_err_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i,
        input  arb_state_o
    );

endinterface

// File: rtl/mem_lane_align.sv
// ---------------------------------------------------------------------------
// mem_lane_align (combinational)
// Maps a data access width and the low address bits onto the 4 byte lanes.
//   i_width    access width code (MEM_W_*)
//   i_lane     addr[1:0]
//   i_sext     1 sign-extend loads, 0 zero-extend
//   i_wdata    right-justified store data
//   i_rdata    raw memory read word
//   o_be       byte enables
//   o_misalign misaligned or illegal width
//   o_wdata    store data replicated across lanes
//   o_rdata    selected load lane, extended to 32 bits
// ---------------------------------------------------------------------------
module mem_lane_align
    import mem_arb_pkg::*;
(
    input  logic [1:0]       i_width,
    input  logic [1:0]       i_lane,
    input  logic             i_sext,
    input  logic [DW-1:0]    i_wdata,
    input  logic [DW-1:0]    i_rdata,
    output logic [LANES-1:0] o_be,
    output logic             o_misalign,
    output logic [DW-1:0]    o_wdata,
    output logic [DW-1:0]    o_rdata
);

    logic [DW-1:0] w_shifted;

    always_comb begin
        o_be       = '0;
        o_misalign = 1'b0;
        o_wdata    = i_wdata;
        o_rdata    = i_rdata;
        // bring the addressed lane down to bit 0
        w_shifted  = i_rdata >> {i_lane, 3'b000};
        case (i_width)
            MEM_W_BYTE: begin
                o_be    = 4'b0001 << i_lane;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = {{24{i_sext & w_shifted[7]}}, w_shifted[7:0]};
            end
            MEM_W_HALF: begin
                o_be       = 4'b0011 << i_lane;
                o_misalign = i_lane[0];
                o_wdata    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{i_sext & w_shifted[15]}}, w_shifted[15:0]};
            end
            MEM_W_WORD: begin
                o_be       = 4'b1111;
                o_misalign = |i_lane;
            end
            default: begin
                o_misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares one single-ported memory between instruction fetch and data access.
// Grants are registered in IDLE; the granted payload is held on the memory
// port through BUSY_x; the requester's ack pulses in DONE, which also acts as
// a bubble so the acked requester has dropped req before re-arbitration.
// Misaligned/illegal data accesses skip the memory and go IDLE -> DONE.
//   clk_i, rst_n_i  clock, asynchronous active-low reset
//   bus             mem_port_arbiter_if.master (fetch, data, memory, debug)
// Build option ARB_FAIR_EN: alternating D/I priority on contention
// (default: fixed D-over-I priority).
// ---------------------------------------------------------------------------
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW = 32
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    mem_port_arbiter_if.master  bus
);

    localparam logic [AW-1:0] WORD_MASK = ~(AW'(3));

    arb_state_e       r_state;
    arb_state_e       w_next;

    logic             r_is_d;
    logic             r_we;
    logic             r_err;
    logic             r_sext;
    logic [1:0]       r_width;
    logic [1:0]       r_lane;
    logic [AW-1:0]    r_addr;
    logic [LANES-1:0] r_be;
    logic [DW-1:0]    r_wdata;
    logic [DW-1:0]    r_rdata;

    logic             w_in_idle;
    logic             w_busy;
    logic             w_done;
    logic             w_pick_d;
    logic             w_grant_d;
    logic             w_grant_i;
    logic [1:0]       w_al_width;
    logic [1:0]       w_al_lane;
    logic             w_al_sext;
    logic [LANES-1:0] w_be;
    logic             w_misalign;
    logic [DW-1:0]    w_wdata_rep;
    logic [DW-1:0]    w_rdata_ext;

    assign w_in_idle = (r_state == IDLE);
    assign w_busy    = (r_state == BUSY_I) || (r_state == BUSY_D);
    assign w_done    = (r_state == DONE);

`ifdef ARB_FAIR_EN
    // 1 = last grant went to D; reset favours D on the first contest
    logic r_last_d;

    assign w_pick_d = bus.dm_req_i & (~bus.if_req_i | ~r_last_d);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_last_d <= 1'b0;
        end else if (w_in_idle && (bus.dm_req_i || bus.if_req_i)) begin
            r_last_d <= w_pick_d;
        end
    end
`else
    assign w_pick_d = bus.dm_req_i;
`endif

    assign w_grant_d = w_in_idle & w_pick_d;
    assign w_grant_i = w_in_idle & bus.if_req_i & ~w_pick_d;

    // In IDLE the aligner looks at the live request (grant, BE, misalign);
    // afterwards it looks at the captured access to extend the returned word.
    assign w_al_width = w_in_idle ? bus.dm_width_i     : r_width;
    assign w_al_lane  = w_in_idle ? bus.dm_addr_i[1:0] : r_lane;
    assign w_al_sext  = w_in_idle ? bus.dm_sext_i      : r_sext;

    mem_lane_align u_align (
        .i_width    (w_al_width),
        .i_lane     (w_al_lane),
        .i_sext     (w_al_sext),
        .i_wdata    (bus.dm_wdata_i),
        .i_rdata    (bus.mem_rdata_i),
        .o_be       (w_be),
        .o_misalign (w_misalign),
        .o_wdata    (w_wdata_rep),
        .o_rdata    (w_rdata_ext)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_d) begin
                    w_next = w_misalign ? DONE : BUSY_D;
                end else if (w_grant_i) begin
                    w_next = BUSY_I;
                end
            end
            BUSY_I, BUSY_D: begin
                if (bus.mem_ack_i) begin
                    w_next = DONE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_is_d  <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_sext  <= 1'b0;
            r_width <= '0;
            r_lane  <= '0;
            r_addr  <= '0;
            r_be    <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_d) begin
                        r_is_d  <= 1'b1;
                        r_we    <= bus.dm_we_i;
                        r_err   <= w_misalign;
                        r_sext  <= bus.dm_sext_i;
                        r_width <= bus.dm_width_i;
                        r_lane  <= bus.dm_addr_i[1:0];
                        r_addr  <= bus.dm_addr_i & WORD_MASK;
                        r_be    <= w_be;
                        r_wdata <= w_wdata_rep;
                        r_rdata <= '0;
                    end else if (w_grant_i) begin
                        r_is_d  <= 1'b0;
                        r_we    <= 1'b0;
                        r_err   <= 1'b0;
                        r_addr  <= bus.if_addr_i & WORD_MASK;
                        r_be    <= '1;
                        r_wdata <= '0;
                        r_rdata <= '0;
                    end
                end
                BUSY_I: begin
                    if (bus.mem_ack_i) begin
                        r_rdata <= bus.mem_rdata_i;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack_i) begin
                        r_rdata <= r_we ? '0 : w_rdata_ext;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.mem_req_o   = w_busy;
    assign bus.mem_we_o    = w_busy & r_we;
    assign bus.mem_addr_o  = w_busy ? r_addr  : '0;
    assign bus.mem_be_o    = w_busy ? r_be    : '0;
    assign bus.mem_wdata_o = w_busy ? r_wdata : '0;

    assign bus.if_ack_o    = w_done & ~r_is_d;
    assign bus.if_rdata_o  = bus.if_ack_o ? r_rdata : '0;
    assign bus.dm_ack_o    = w_done & r_is_d;
    assign bus.dm_rdata_o  = bus.dm_ack_o ? r_rdata : '0;
    assign bus.dm_err_o    = bus.dm_ack_o & r_err;

    assign bus.arb_state_o = r_state;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed bench for mem_port_arbiter with hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic clk_i;
    logic rst_n_i;

    int n_checks;
    int n_pass;

    logic [31:0] exp_q[$];

    mem_port_arbiter_if #(.AW(32)) bus ();

    mem_port_arbiter #(.AW(32)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus.if_req_i    = 1'b0;
        bus.if_addr_i   = '0;
        bus.dm_req_i    = 1'b0;
        bus.dm_we_i     = 1'b0;
        bus.dm_addr_i   = '0;
        bus.dm_width_i  = MEM_W_WORD;
        bus.dm_sext_i   = 1'b0;
        bus.dm_wdata_i  = '0;
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
    endtask

    task automatic drive_dm(input logic we, input logic [31:0] addr, input logic [1:0] w,
                            input logic sx, input logic [31:0] wd);
        bus.dm_req_i   = 1'b1;
        bus.dm_we_i    = we;
        bus.dm_addr_i  = addr;
        bus.dm_width_i = w;
        bus.dm_sext_i  = sx;
        bus.dm_wdata_i = wd;
    endtask

    // One aligned data transaction with a 1-cycle memory.
    task automatic dm_txn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [1:0] w, input logic sx, input logic [31:0] wd,
                          input logic [31:0] word, input logic [3:0] ebe,
                          input logic [31:0] ewd, input logic [31:0] erd);
        drive_dm(we, addr, w, sx, wd);
        step();
        check({tag, "_mem_req"}, 32'(bus.mem_req_o), 32'd1);
        check({tag, "_mem_addr"}, bus.mem_addr_o, addr & 32'hFFFF_FFFC);
        check({tag, "_mem_be"}, 32'(bus.mem_be_o), 32'(ebe));
        check({tag, "_mem_we"}, 32'(bus.mem_we_o), 32'(we));
        if (we) check({tag, "_mem_wdata"}, bus.mem_wdata_o, ewd);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = word;
        step();
        bus.mem_ack_i   = 1'b0;
        bus.dm_req_i    = 1'b0;
        check({tag, "_dm_ack"}, 32'(bus.dm_ack_o), 32'd1);
        check({tag, "_dm_rdata"}, bus.dm_rdata_o, erd);
        check({tag, "_dm_err"}, 32'(bus.dm_err_o), 32'd0);
        check({tag, "_req_low_done"}, 32'(bus.mem_req_o), 32'd0);
        step();
        check({tag, "_ack_pulse"}, 32'(bus.dm_ack_o), 32'd0);
    endtask

    // Misaligned / illegal access: no memory cycle, error ack next cycle.
    task automatic err_txn(input string tag, input logic [31:0] addr, input logic [1:0] w);
        drive_dm(1'b0, addr, w, 1'b0, 32'h0);
        step();
        check({tag, "_no_mem_req"}, 32'(bus.mem_req_o), 32'd0);
        check({tag, "_dm_ack"}, 32'(bus.dm_ack_o), 32'd1);
        check({tag, "_dm_err"}, 32'(bus.dm_err_o), 32'd1);
        check({tag, "_dm_rdata"}, bus.dm_rdata_o, 32'd0);
        bus.dm_req_i = 1'b0;
        step();
        check({tag, "_ack_pulse"}, 32'(bus.dm_ack_o), 32'd0);
    endtask

    // One contested round: both requesters pending; exp_d=1 means D wins.
    task automatic grant_round(input int idx, input logic [31:0] exp_d);
        int n;
        logic won_d;
        n = 0;
        while (!bus.mem_req_o && n < 8) begin
            step();
            n++;
        end
        check($sformatf("rr%0d_grant_seen", idx), 32'(bus.mem_req_o), 32'd1);
        won_d = (bus.mem_addr_o == 32'h200);
        check($sformatf("rr%0d_owner_d", idx), 32'(won_d), exp_d);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h0000_0A00 + 32'(idx);
        step();
        bus.mem_ack_i = 1'b0;
        if (exp_d[0]) begin
            check($sformatf("rr%0d_dm_ack", idx), 32'(bus.dm_ack_o), 32'd1);
            bus.dm_req_i = 1'b0;
        end else begin
            check($sformatf("rr%0d_if_ack", idx), 32'(bus.if_ack_o), 32'd1);
            bus.if_req_i = 1'b0;
        end
        step();
        bus.dm_req_i = 1'b1;
        bus.if_req_i = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_checks = 0;
        n_pass   = 0;
        idle_inputs();
        rst_n_i = 1'b0;
        #1;
        check("rst_state", 32'(bus.arb_state_o), 32'(IDLE));
        check("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("rst_if_ack", 32'(bus.if_ack_o), 32'd0);
        check("rst_dm_ack", 32'(bus.dm_ack_o), 32'd0);
        step();
        step();
        rst_n_i = 1'b1;
        step();

        // 1: fetch only, 1-cycle memory
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h40;
        check("t1_no_req_same_cycle", 32'(bus.mem_req_o), 32'd0);
        step();
        check("t1_mem_req", 32'(bus.mem_req_o), 32'd1);
        check("t1_mem_addr", bus.mem_addr_o, 32'h40);
        check("t1_mem_be", 32'(bus.mem_be_o), 32'hF);
        check("t1_mem_we", 32'(bus.mem_we_o), 32'd0);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h0050_0093;
        step();
        bus.mem_ack_i = 1'b0;
        check("t1_if_ack", 32'(bus.if_ack_o), 32'd1);
        check("t1_if_rdata", bus.if_rdata_o, 32'h0050_0093);
        check("t1_mem_req_done", 32'(bus.mem_req_o), 32'd0);
        bus.if_req_i = 1'b0;
        step();
        check("t1_ack_pulse", 32'(bus.if_ack_o), 32'd0);

        // 2: simultaneous requests, D first, I two cycles after dm_ack
        drive_dm(1'b0, 32'h200, MEM_W_WORD, 1'b0, 32'h0);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h300;
        step();
        check("t2_first_addr", bus.mem_addr_o, 32'h200);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h1122_3344;
        step();
        bus.mem_ack_i = 1'b0;
        check("t2_dm_ack", 32'(bus.dm_ack_o), 32'd1);
        check("t2_if_no_ack", 32'(bus.if_ack_o), 32'd0);
        check("t2_dm_rdata", bus.dm_rdata_o, 32'h1122_3344);
        bus.dm_req_i = 1'b0;
        step();
        check("t2_bubble", 32'(bus.mem_req_o), 32'd0);
        step();
        check("t2_i_grant", 32'(bus.mem_req_o), 32'd1);
        check("t2_i_addr", bus.mem_addr_o, 32'h300);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'h0000_0013;
        step();
        bus.mem_ack_i = 1'b0;
        check("t2_if_ack", 32'(bus.if_ack_o), 32'd1);
        check("t2_if_rdata", bus.if_rdata_o, 32'h0000_0013);
        bus.if_req_i = 1'b0;
        step();

        // 2b: repeated contention
`ifdef ARB_FAIR_EN
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'd1);
`else
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
        exp_q.push_back(32'd1);
`endif
        drive_dm(1'b0, 32'h200, MEM_W_WORD, 1'b0, 32'h0);
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h300;
        for (int r = 0; r < 3; r++) begin
            grant_round(r, exp_q.pop_front());
        end
        bus.dm_req_i = 1'b0;
        bus.if_req_i = 1'b0;
        step();
        step();

        // 3: byte loads with sign and zero extension
        dm_txn("t3_lb", 1'b0, 32'h103, MEM_W_BYTE, 1'b1, 32'h0, 32'h80FF_1234,
               4'b1000, 32'h0, 32'hFFFF_FF80);
        dm_txn("t3_lbu", 1'b0, 32'h103, MEM_W_BYTE, 1'b0, 32'h0, 32'h80FF_1234,
               4'b1000, 32'h0, 32'h0000_0080);
        dm_txn("t3_lh", 1'b0, 32'h102, MEM_W_HALF, 1'b1, 32'h0, 32'h80FF_1234,
               4'b1100, 32'h0, 32'hFFFF_80FF);

        // 4: half store
        dm_txn("t4_sh", 1'b1, 32'h102, MEM_W_HALF, 1'b0, 32'h0000_ABCD, 32'h5555_5555,
               4'b1100, 32'hABCD_ABCD, 32'h0);
        dm_txn("t4_sb", 1'b1, 32'h101, MEM_W_BYTE, 1'b0, 32'h0000_005A, 32'h0,
               4'b0010, 32'h5A5A_5A5A, 32'h0);

        // 5: misaligned / illegal
        err_txn("t5_lw_mis", 32'h102, MEM_W_WORD);
        err_txn("t5_lh_mis", 32'h101, MEM_W_HALF);
        err_txn("t5_ill", 32'h100, MEM_W_ILL);

        // requester drops mid-BUSY; memory stalls one cycle
        bus.if_req_i  = 1'b1;
        bus.if_addr_i = 32'h84;
        step();
        check("drop_mem_req", 32'(bus.mem_req_o), 32'd1);
        bus.if_req_i = 1'b0;
        step();
        check("drop_req_held", 32'(bus.mem_req_o), 32'd1);
        check("drop_addr_held", bus.mem_addr_o, 32'h84);
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = 32'hDEAD_BEEF;
        step();
        bus.mem_ack_i = 1'b0;
        check("drop_if_ack", 32'(bus.if_ack_o), 32'd1);
        check("drop_if_rdata", bus.if_rdata_o, 32'hDEAD_BEEF);
        step();

        // mem_ack_i while idle is ignored
        bus.mem_ack_i = 1'b1;
        step();
        bus.mem_ack_i = 1'b0;
        check("stray_ack_if", 32'(bus.if_ack_o), 32'd0);
        check("stray_ack_dm", 32'(bus.dm_ack_o), 32'd0);
        check("stray_ack_state", 32'(bus.arb_state_o), 32'(IDLE));
        step();

        // 6: reset during BUSY_D with a stalling memory
        drive_dm(1'b0, 32'h1F0, MEM_W_WORD, 1'b0, 32'h0);
        step();
        check("t6_busy_d", 32'(bus.arb_state_o), 32'(BUSY_D));
        step();
        rst_n_i = 1'b0;
        #1;
        check("t6_rst_mem_req", 32'(bus.mem_req_o), 32'd0);
        check("t6_rst_mem_addr", bus.mem_addr_o, 32'd0);
        check("t6_rst_mem_be", 32'(bus.mem_be_o), 32'd0);
        bus.dm_req_i = 1'b0;
        step();
        rst_n_i = 1'b1;
        step();
        check("t6_idle", 32'(bus.arb_state_o), 32'(IDLE));
        check("t6_no_ack", 32'(bus.dm_ack_o), 32'd0);
        step();
        check("t6_no_ack2", 32'(bus.dm_ack_o), 32'd0);
        check("t6_no_mem_req", 32'(bus.mem_req_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
